// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package rv_fetch_pkg;

    localparam int unsigned XLEN             = 32;
    localparam int unsigned INSTR_BYTES      = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

    // Sequential fetch address, wrapping modulo 2^XLEN.
    function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/fetch_resp_fifo.sv
// Small synchronous FIFO with synchronous flush; used both for fetched
// responses {pc, instr} and for the queue of PCs awaiting a response.
module fetch_resp_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             full_s;
    logic             do_pop_s;
    logic             do_push_s;

    assign full_s    = (count_r == CW'(DEPTH));
    assign empty     = (count_r == CW'(0));
    assign count     = count_r;
    assign head_data = mem_r[rd_ptr_r];
    assign do_pop_s  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push_s = push & (~full_s | do_pop_s);

    // Storage, pointers and occupancy; flush empties without touching storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else if (flush) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues credit-limited imem reads and
// hands {instr, pc, pc+4} to IF/ID. Define FETCH_PERF_CNT_EN for perf counters.
module if_fetch_unit
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [31:0] pcplus4_out
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_redirects
`endif
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t  state_r;
    fetch_state_t  state_s;
    logic [31:0]   fetch_pc_r;
    logic [31:0]   fetch_pc_s;
    logic [CW-1:0] discard_r;
    logic [CW-1:0] discard_s;
    logic [CW-1:0] inflight_s;
    logic [CW-1:0] resp_count_s;
    logic [CW-1:0] pend_count_s;
    logic [CW:0]   credit_sum_s;
    logic          credit_s;
    logic          resp_empty_s;
    logic          pend_empty_s;
    logic [63:0]   resp_head_s;
    logic [31:0]   pend_head_s;
    logic          rsp_push_s;
    logic          out_pop_s;
    logic          issue_s;

    assign credit_sum_s = {1'b0, resp_count_s} + {1'b0, pend_count_s};
    assign credit_s     = (credit_sum_s < (CW + 1)'(FIFO_DEPTH));
    assign issue_s      = imem_req & imem_gnt;
    assign out_pop_s    = ~resp_empty_s & out_ready & ~redirect_valid;

    assign imem_addr    = fetch_pc_r;
    assign out_valid    = ~resp_empty_s;
    assign instr_out    = resp_empty_s ? 32'h0000_0000 : resp_head_s[31:0];
    assign pc_out       = resp_empty_s ? 32'h0000_0000 : resp_head_s[63:32];
    assign pcplus4_out  = resp_empty_s ? 32'h0000_0000 : pc_inc(resp_head_s[63:32]);

    // Addresses of granted requests, oldest first; emptied on redirect.
    fetch_resp_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH), .CW(CW)) u_pend_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (issue_s),
        .push_data (fetch_pc_r),
        .pop       (rsp_push_s),
        .head_data (pend_head_s),
        .empty     (pend_empty_s),
        .count     (pend_count_s)
    );

    fetch_resp_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH), .CW(CW)) u_resp_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (rsp_push_s),
        .push_data ({pend_head_s, imem_rdata}),
        .pop       (out_pop_s),
        .head_data (resp_head_s),
        .empty     (resp_empty_s),
        .count     (resp_count_s)
    );

    // Fetch state, PC and wrong-path discard counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= FETCH;
            fetch_pc_r <= RESET_PC;
            discard_r  <= CW'(0);
        end else begin
            state_r    <= state_s;
            fetch_pc_r <= fetch_pc_s;
            discard_r  <= discard_s;
        end
    end

    // Next-state, request and response-acceptance logic; redirect overrides all.
    always_comb begin
        state_s    = state_r;
        fetch_pc_s = fetch_pc_r;
        discard_s  = discard_r;
        inflight_s = pend_count_s;
        imem_req   = 1'b0;
        rsp_push_s = 1'b0;
        case (state_r)
            FETCH: begin
                imem_req = credit_s & ~redirect_valid & ~reset;
                if (imem_rvalid && !pend_empty_s) begin
                    inflight_s = pend_count_s - CW'(1);
                    rsp_push_s = ~redirect_valid;
                end else begin
                    inflight_s = pend_count_s;
                end
                if (redirect_valid) begin
                    fetch_pc_s = redirect_pc & 32'hFFFF_FFFC;
                    if (inflight_s != CW'(0)) begin
                        state_s   = DRAIN;
                        discard_s = inflight_s;
                    end else begin
                        state_s   = FETCH;
                        discard_s = CW'(0);
                    end
                end else if (issue_s) begin
                    fetch_pc_s = pc_inc(fetch_pc_r);
                end else begin
                    fetch_pc_s = fetch_pc_r;
                end
            end
            DRAIN: begin
                // Nothing is issued here, so a redirect never adds to discard.
                if (imem_rvalid && (discard_r != CW'(0))) begin
                    discard_s = discard_r - CW'(1);
                end else begin
                    discard_s = discard_r;
                end
                if (discard_s == CW'(0)) begin
                    state_s = FETCH;
                end else begin
                    state_s = DRAIN;
                end
                if (redirect_valid) begin
                    fetch_pc_s = redirect_pc & 32'hFFFF_FFFC;
                end else begin
                    fetch_pc_s = fetch_pc_r;
                end
            end
            default: begin
                state_s   = FETCH;
                discard_s = CW'(0);
            end
        endcase
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_r;
    logic [31:0] perf_redir_r;

    // Stall-cycle and redirect-pulse counters, free-running with wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_r <= 32'h0000_0000;
            perf_redir_r <= 32'h0000_0000;
        end else begin
            if (out_valid && !out_ready) begin
                perf_stall_r <= perf_stall_r + 32'd1;
            end
            if (redirect_valid) begin
                perf_redir_r <= perf_redir_r + 32'd1;
            end
        end
    end

    assign perf_stall_cycles = perf_stall_r;
    assign perf_redirects    = perf_redir_r;
`else
    // Build without performance counters.
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: memory responder plus handshake recorder,
// hand-derived expected PCs per scenario.
`timescale 1ns/1ps
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [31:0] pcplus4_out;

    int checks = 0;
    int failures = 0;
    bit mem_hold = 1'b0;

    logic [31:0] mem_q[$];
    logic [31:0] issue_q[$];
    logic [31:0] got_pc_q[$];
    logic [31:0] got_p4_q[$];
    logic [31:0] got_in_q[$];

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .instr_out      (instr_out),
        .pc_out         (pc_out),
        .pcplus4_out    (pcplus4_out)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_entry(input string tag, input int idx, input logic [31:0] exp_pc);
        check_eq({tag, "_pc"}, (got_pc_q.size() > idx) ? got_pc_q[idx] : 32'hEEEE_EEEE, exp_pc);
        check_eq({tag, "_in"}, (got_in_q.size() > idx) ? got_in_q[idx] : 32'hEEEE_EEEE, instr_of(exp_pc));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        issue_q.delete();
        got_pc_q.delete();
        got_p4_q.delete();
        got_in_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        tick();
        tick();
        mem_q.delete();
        clear_logs();
        reset = 1'b0;
    endtask

    // Mid-cycle recorder: granted requests and accepted outputs.
    always @(negedge clk) begin
        if (!reset) begin
            if (imem_req && imem_gnt) begin
                mem_q.push_back(imem_addr);
                issue_q.push_back(imem_addr);
            end
            if (out_valid && out_ready && !redirect_valid) begin
                got_pc_q.push_back(pc_out);
                got_p4_q.push_back(pcplus4_out);
                got_in_q.push_back(instr_out);
            end
        end
    end

    // Memory: answers each grant in order, one cycle later unless held.
    always @(posedge clk) begin
        #2;
        if (!mem_hold && mem_q.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = instr_of(mem_q.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        imem_gnt = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check_eq("rst_req",   32'(imem_req),  32'h0);
        check_eq("rst_valid", 32'(out_valid), 32'h0);
        check_eq("rst_pc",    pc_out,         32'h0);
        check_eq("rst_instr", instr_out,      32'h0);
        check_eq("rst_p4",    pcplus4_out,    32'h0);

        // 1: sequential fetch and two-cycle latency
        do_reset();
        @(negedge clk);
        check_eq("t1_req0",  32'(imem_req),  32'h1);
        check_eq("t1_addr0", imem_addr,      32'h0);
        check_eq("t1_v0",    32'(out_valid), 32'h0);
        @(negedge clk);
        check_eq("t1_v1",    32'(out_valid), 32'h0);
        @(negedge clk);
        check_eq("t1_v2",    32'(out_valid), 32'h1);
        check_eq("t1_pc",    pc_out,         32'h0);
        check_eq("t1_p4",    pcplus4_out,    32'h4);
        tick();
        repeat (12) tick();
        check_entry("t1_e0", 0, 32'h0);
        check_entry("t1_e1", 1, 32'h4);
        check_entry("t1_e2", 2, 32'h8);
        check_entry("t1_e3", 3, 32'hC);
        check_entry("t1_e4", 4, 32'h10);
        check_eq("t1_p4_e3", (got_p4_q.size() > 3) ? got_p4_q[3] : 32'hEEEE_EEEE, 32'h10);

        // 2: downstream stall fills credits, then drains in order
        out_ready = 1'b0;
        do_reset();
        repeat (10) tick();
        @(negedge clk);
        check_eq("t2_req",    32'(imem_req),       32'h0);
        check_eq("t2_valid",  32'(out_valid),      32'h1);
        check_eq("t2_head",   pc_out,              32'h0);
        check_eq("t2_issued", 32'(issue_q.size()), 32'h2);
        tick();
        out_ready = 1'b1;
        repeat (10) tick();
        check_entry("t2_e0", 0, 32'h0);
        check_entry("t2_e1", 1, 32'h4);
        check_entry("t2_e2", 2, 32'h8);
        check_entry("t2_e3", 3, 32'hC);

        // 3: redirect with two responses in flight
        mem_hold = 1'b1;
        do_reset();
        repeat (4) tick();
        @(negedge clk);
        check_eq("t3_req_full", 32'(imem_req),  32'h0);
        check_eq("t3_valid",    32'(out_valid), 32'h0);
        tick();
        redirect_pc = 32'h0000_0100;
        redirect_valid = 1'b1;
        @(negedge clk);
        check_eq("t3_req_redir", 32'(imem_req), 32'h0);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check_eq("t3_req_drain", 32'(imem_req), 32'h0);
        tick();
        mem_hold = 1'b0;
        repeat (10) tick();
        check_entry("t3_e0", 0, 32'h100);
        check_entry("t3_e1", 1, 32'h104);
        check_eq("t3_issue2", (issue_q.size() > 2) ? issue_q[2] : 32'hEEEE_EEEE, 32'h100);

        // 4: redirect together with a response and an output pop
        do_reset();
        tick();
        tick();
        redirect_pc = 32'h0000_0300;
        redirect_valid = 1'b1;
        @(negedge clk);
        check_eq("t4_valid_pre", 32'(out_valid), 32'h1);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check_eq("t4_flushed", 32'(out_valid), 32'h0);
        check_eq("t4_req",     32'(imem_req),  32'h1);
        check_eq("t4_addr",    imem_addr,      32'h300);
        repeat (10) tick();
        check_entry("t4_e0", 0, 32'h300);
        check_entry("t4_e1", 1, 32'h304);

        // 5: PC wrap and redirect alignment
        imem_gnt = 1'b0;
        do_reset();
        redirect_pc = 32'hFFFF_FFFC;
        redirect_valid = 1'b1;
        tick();
        redirect_valid = 1'b0;
        imem_gnt = 1'b1;
        @(negedge clk);
        check_eq("t5_addr", imem_addr, 32'hFFFF_FFFC);
        repeat (10) tick();
        check_entry("t5_e0", 0, 32'hFFFF_FFFC);
        check_eq("t5_p4_e0", (got_p4_q.size() > 0) ? got_p4_q[0] : 32'hEEEE_EEEE, 32'h0);
        check_entry("t5_e1", 1, 32'h0);
        check_eq("t5_p4_e1", (got_p4_q.size() > 1) ? got_p4_q[1] : 32'hEEEE_EEEE, 32'h4);
        imem_gnt = 1'b0;
        repeat (5) tick();
        redirect_pc = 32'h0000_0103;
        redirect_valid = 1'b1;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check_eq("t5_align_addr", imem_addr,     32'h100);
        check_eq("t5_align_req",  32'(imem_req), 32'h1);
        tick();
        clear_logs();
        imem_gnt = 1'b1;
        repeat (8) tick();
        check_entry("t5_e2", 0, 32'h100);

        // 6: reset with requests outstanding, stale responses afterwards
        mem_hold = 1'b1;
        do_reset();
        repeat (3) tick();
        reset = 1'b1;
        imem_gnt = 1'b0;
        mem_q.delete();
        mem_q.push_back(32'hBAD0_0000);
        mem_q.push_back(32'hBAD0_0004);
        tick();
        tick();
        reset = 1'b0;
        mem_hold = 1'b0;
        @(negedge clk);
        check_eq("t6_v0",   32'(out_valid), 32'h0);
        check_eq("t6_req",  32'(imem_req),  32'h1);
        check_eq("t6_addr", imem_addr,      32'h0);
        tick();
        @(negedge clk);
        check_eq("t6_v1", 32'(out_valid), 32'h0);
        tick();
        @(negedge clk);
        check_eq("t6_v2", 32'(out_valid), 32'h0);
        tick();
        clear_logs();
        imem_gnt = 1'b1;
        repeat (10) tick();
        check_entry("t6_e0", 0, 32'h0);
        check_entry("t6_e1", 1, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
